dmem_store_buffer: RTL
======================

# dmem_store_buffer

Data-memory responder for the pipelined MIPS core, sitting on the core's store/load bus (`dataadr`, `writedata`, `memwrite`) as the memory end of that interface. Stores are accepted into a small FIFO store buffer and retired to a single-port word RAM whenever the port is free. Loads return a word merged from RAM and any younger buffered bytes via store-to-load forwarding. A `stall` output back-pressures the core when the buffer is full.

## Interface
- `RAM_WORDS`, default 64: RAM depth in 32-bit words; power of 2.
- `SB_DEPTH`, default 4: store-buffer entries; power of 2, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; low clears buffer state immediately.
- `memwrite` in 2: store request/size; 00 none, 01 byte, 10 halfword, 11 word.
- `memread` in 1: load in progress this cycle; blocks drain.
- `dataadr` in 32: byte address for loads and stores.
- `writedata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `readdata` out 32: combinational load word, forwarding applied.
- `stall` out 1: combinational; store presented but not accepted.
- `sb_empty` out 1: buffer holds no entries.
- `align_err` out 1: sticky; a misaligned store was dropped.

## Operation
- Word index = `dataadr[log2(RAM_WORDS)+1:2]`; upper address bits ignored (wrap modulo RAM size). Byte lane = `dataadr[1:0]`, little-endian: lane 0 = bits [7:0].
- Entry contents: word index, 4-bit byte enable, 32-bit lane-aligned data. Byte: BE = 1<<lane, data replicated to that lane. Half: `dataadr[0]` must be 0; BE = 0011 or 1100 by `dataadr[1]`. Word: `dataadr[1:0]` must be 00; BE = 1111.
- Misaligned store: not enqueued, no stall, `align_err` set until reset.
- Enqueue: at rising edge when `memwrite`≠00, aligned, and `stall`=0. Write to tail, tail+1, count+1.
- `stall` = (`memwrite`≠00) & (count==SB_DEPTH) & aligned. Stall does not depend on a same-cycle drain. Core holds the request until `stall` falls.
- Drain: at rising edge when count>0 and `memread`=0. Head entry written to RAM under its BE only; head+1, count−1.
- Enqueue and drain on the same edge: count unchanged, both pointers advance.
- Load forwarding, combinational, per byte lane of the addressed word: the youngest valid entry with matching word index and BE bit set supplies the byte; otherwise the RAM byte. `readdata` is always the full word; the core extracts sub-words.
- `memread` and `memwrite` both active: store handled normally, drain blocked.
- Pointers wrap modulo SB_DEPTH; count range 0..SB_DEPTH (width log2(SB_DEPTH)+1).

## Timing
- Reset (asserted): count=0, head=tail=0, `sb_empty`=1, `stall`=0, `align_err`=0. RAM contents are not reset.
- Reset asserted mid-operation: all buffered stores are discarded, and none reach RAM.
- Store-to-load latency: a store accepted at edge N is visible on `readdata` in the cycle after edge N, via forwarding.
- RAM write latency: the earliest drain of an entry enqueued at edge N is edge N+1. Worst case is unbounded while `memread` is held high.
- `readdata` is valid the same cycle as `dataadr`, with no registered output.
- `stall` and `sb_empty` reflect state after the most recent edge, plus current inputs for `stall`.

## Test plan
- Word round-trip: reset, sw 32'h41800888 @84, then idle 2 cycles, lw @84 -> `readdata`=32'h41800888; `sb_empty`=1 after the drain edge.
- Forwarding before drain: hold `memread`=1 continuously; sw 32'h11223344 @8, then sb 8'hAA @9 -> next cycle `readdata`@8 = 32'h1122AA44; `sb_empty`=0 throughout.
- Full/stall: `memread`=1, issue 5 word stores @0,4,8,12,16 -> `stall`=1 on the 5th; drop `memread` -> one drain edge, 5th accepted next edge; all five words read back correct.
- Youngest-wins: sw 32'hFFFFFFFF @20, then sh 16'h1234 @22, then sh 16'h5678 @22, all with `memread`=1 -> `readdata`@20 = 32'h5678FFFF; after drain, same value from RAM.
- Misalignment: sh @3, then sw @6 -> neither enqueued, `align_err`=1, `stall`=0, `sb_empty` stays 1.
- Async reset mid-operation: buffer 3 stores with `memread`=1, pulse `reset` low between edges -> `sb_empty`=1 immediately, `align_err`=0, and RAM unchanged at those addresses.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - data-memory responder with FIFO store buffer, word RAM and store-to-load forwarding
module dmem_store_buffer #(
   parameter int RAM_WORDS = 64,
   parameter int SB_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  memwrite,
   input  logic        memread,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        stall,
   output logic        sb_empty,
   output logic        align_err
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(SB_DEPTH);

   logic [31:0]   ram_q     [RAM_WORDS];
   logic [AW-1:0] sb_idx_q  [SB_DEPTH];
   logic [3:0]    sb_be_q   [SB_DEPTH];
   logic [31:0]   sb_data_q [SB_DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic          align_err_q, align_err_d;

   logic [AW-1:0] addr_idx;
   logic [1:0]    lane;
   logic          st_req, st_ok, full, enq, drain;
   logic [3:0]    st_be;
   logic [31:0]   st_data;
   logic [31:0]   rd_word;
   logic          unused_addr;

   assign addr_idx    = dataadr[AW+1:2];
   assign lane        = dataadr[1:0];
   assign unused_addr = ^dataadr[31:AW+2];

   // Store data is replicated across lanes so the BE alone selects what lands.
   always_comb begin
      st_ok   = 1'b0;
      st_be   = 4'b0000;
      st_data = 32'h0;
      case (memwrite)
         2'b01: begin
            st_ok   = 1'b1;
            st_be   = 4'b0001 << lane;
            st_data = {4{writedata[7:0]}};
         end
         2'b10: begin
            st_ok   = ~dataadr[0];
            st_be   = dataadr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{writedata[15:0]}};
         end
         2'b11: begin
            st_ok   = (lane == 2'b00);
            st_be   = 4'b1111;
            st_data = writedata;
         end
         default: ;
      endcase
   end

   assign st_req = (memwrite != 2'b00);
   assign full   = (count_q == (PW+1)'(SB_DEPTH));
   assign stall  = st_req & st_ok & full;
   assign enq    = st_req & st_ok & ~full;
   assign drain  = (count_q != '0) & ~memread;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      align_err_d = align_err_q | (st_req & ~st_ok);
      if (enq)   tail_d = tail_q + 1'b1;
      if (drain) head_d = head_q + 1'b1;
      if (enq && !drain)      count_d = count_q + 1'b1;
      else if (!enq && drain) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         align_err_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         align_err_q <= align_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         sb_idx_q[tail_q]  <= addr_idx;
         sb_be_q[tail_q]   <= st_be;
         sb_data_q[tail_q] <= st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (drain) begin
         for (int l = 0; l < 4; l++) begin
            if (sb_be_q[head_q][l])
               ram_q[sb_idx_q[head_q]][8*l +: 8] <= sb_data_q[head_q][8*l +: 8];
         end
      end
   end

   // Walk oldest to youngest so the youngest matching byte overrides.
   always_comb begin
      rd_word = ram_q[addr_idx];
      for (int k = 0; k < SB_DEPTH; k++) begin
         if (((PW+1)'(k) < count_q) && (sb_idx_q[head_q + PW'(k)] == addr_idx)) begin
            for (int l = 0; l < 4; l++) begin
               if (sb_be_q[head_q + PW'(k)][l])
                  rd_word[8*l +: 8] = sb_data_q[head_q + PW'(k)][8*l +: 8];
            end
         end
      end
   end

   assign readdata  = rd_word;
   assign sb_empty  = (count_q == '0);
   assign align_err = align_err_q;

endmodule
